conv_layer_input_ctrl: RTL and testbench
========================================

// Module: conv_layer_input_ctrl
// PURPOSE
//  Sequencer for the conv-layer input row buffer and 3x3 kernel datapath. Drives
//  current_state, col_index, row_index and preload_cycle so the buffer preloads
//  KERNEL_SIZE image rows, feeds kernel rows to the MAC, then loads one new row
//  per output row. Sits between the layer top (start/done) and the input buffer.
//  It also gates the upstream pixel source (data_req).
// PARAMETERS
//  IMAGE_SIZE        8  input row length in pixels; must equal the buffer's row width
//  KERNEL_SIZE       3  kernel height/width; equals the buffer row count
//  BUFFER_COL_WIDTH  4  col_index width; must hold IMAGE_SIZE
//  BUFFER_ROW_WIDTH  2  row_index/preload_cycle width; must hold KERNEL_SIZE
//  OUT_ROW_WIDTH     3  out_row width; must hold IMAGE_SIZE-KERNEL_SIZE
// PORTS
//  clk            in   1                 single clock, rising edge
//  rst_n          in   1                 asynchronous active-low reset
//  start          in   1                 1-cycle pulse; sampled only in IDLE
//  current_state  out  3                 IDLE=0 PRELOAD=1 SHIFT=2 BIAS=3 LOAD=4
//  col_index      out  BUFFER_COL_WIDTH  pixel column (PRELOAD/LOAD) or output column (SHIFT)
//  row_index      out  BUFFER_ROW_WIDTH  buffer row to the MAC (SHIFT only, else 0)
//  preload_cycle  out  BUFFER_ROW_WIDTH  index of the row being preloaded
//  data_req       out  1                 buffer samples data_in this cycle
//  out_row        out  OUT_ROW_WIDTH     output row being computed
//  busy           out  1                 high whenever current_state != IDLE
//  done           out  1                 1-cycle pulse, frame complete
// BEHAVIOUR
//  - All outputs are registered, except busy and data_req, which decode the registers.
//  - Reset value of every output is 0 (state IDLE). Reset takes effect mid-frame.
//  - OUT = IMAGE_SIZE-KERNEL_SIZE+1.
//  - IDLE: counters held at 0. A start pulse moves to PRELOAD next cycle with
//    col_index=0 and preload_cycle=0. start is ignored in all other states.
//  - PRELOAD: data_req=1 while col_index<IMAGE_SIZE.
//    - Rows preload_cycle<KERNEL_SIZE-1: col_index runs 0..IMAGE_SIZE. The extra
//      count IMAGE_SIZE is the buffer row-shift cycle with data_req=0. Next cycle:
//      preload_cycle+1, col_index=0.
//    - Last row (preload_cycle=KERNEL_SIZE-1): col_index runs 0..IMAGE_SIZE-1 with
//      no shift cycle. Then SHIFT with col_index=0, row_index=0, out_row=0.
//  - SHIFT: row_index steps 0..KERNEL_SIZE-1 each cycle; col_index advances by 1
//    when row_index wraps. After col_index=OUT-1, row_index=KERNEL_SIZE-1 -> BIAS.
//  - BIAS: exactly 1 cycle.
//    - If out_row<OUT-1, go to LOAD with col_index=0.
//    - Otherwise go to IDLE and pulse done in the same cycle that state=IDLE.
//  - LOAD: data_req=1 for col_index 0..IMAGE_SIZE-1. At col_index=0 the buffer
//    shifts rows and writes pixel 0. After col_index=IMAGE_SIZE-1, go to SHIFT
//    with out_row+1 and col_index=row_index=0.
//  - No stall input. Upstream must present valid data_in in every data_req cycle.
//  - Frame length in cycles, start-to-done:
//    (KERNEL_SIZE-1)*(IMAGE_SIZE+1) + IMAGE_SIZE + OUT*(OUT*KERNEL_SIZE+1)
//    + (OUT-1)*IMAGE_SIZE + 1. This is 181 at the default parameters.
//  - Counters never exceed their terminal values. Out-of-range values are
//    unreachable, and there is no wrap-around beyond the stated limits.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0. Release, no start for 20 cycles -> state stays 0.
//  2 Full frame, defaults:
//    - start -> done exactly 181 cycles later.
//    - data_req count 64, BIAS count 6, LOAD count 5x8 cycles.
//  3 PRELOAD trace:
//    - col_index 0..8, 0..8, 0..7 with preload_cycle 0,1,2.
//    - data_req low only at col_index=8.
//  4 SHIFT trace: row_index 0,1,2 repeating; col_index 0..5; 18 cycles, then state=3.
//  5 Repeated start: pulse start during SHIFT and LOAD -> ignored; the frame
//    timing is identical to test 2.
//  6 Reset mid-frame: rst_n low in LOAD with out_row=3 -> all outputs 0 immediately.
//    A new start then yields a clean 181-cycle frame.

Source files
------------

// File: rtl/conv_layer_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// conv_layer_input_ctrl_if
//   Control bundle between the conv-layer top / input row buffer and the
//   input sequencer.
//   master : layer top side, issues start and consumes the sequencer outputs
//   slave  : the sequencer (conv_layer_input_ctrl)
//   Signals:
//     start          1-cycle frame start pulse
//     current_state  sequencer state (IDLE=0 PRELOAD=1 SHIFT=2 BIAS=3 LOAD=4)
//     col_index      pixel column (PRELOAD/LOAD) or output column (SHIFT)
//     row_index      buffer row presented to the MAC (SHIFT only)
//     preload_cycle  index of the row being preloaded
//     data_req       buffer samples data_in this cycle
//     out_row        output row being computed
//     busy           sequencer not in IDLE
//     done           1-cycle pulse at frame completion
// ----------------------------------------------------------------------------
interface conv_layer_input_ctrl_if #(
  parameter int unsigned BUFFER_COL_WIDTH = 4,
  parameter int unsigned BUFFER_ROW_WIDTH = 2,
  parameter int unsigned OUT_ROW_WIDTH    = 3
);

  logic                        start;
  logic [2:0]                  current_state;
  logic [BUFFER_COL_WIDTH-1:0] col_index;
  logic [BUFFER_ROW_WIDTH-1:0] row_index;
  logic [BUFFER_ROW_WIDTH-1:0] preload_cycle;
  logic                        data_req;
  logic [OUT_ROW_WIDTH-1:0]    out_row;
  logic                        busy;
  logic                        done;

  modport master (
    output start,
    input  current_state,
    input  col_index,
    input  row_index,
    input  preload_cycle,
    input  data_req,
    input  out_row,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    output current_state,
    output col_index,
    output row_index,
    output preload_cycle,
    output data_req,
    output out_row,
    output busy,
    output done
  );

endinterface : conv_layer_input_ctrl_if

// File: rtl/conv_layer_input_ctrl.sv
// ----------------------------------------------------------------------------
// conv_layer_input_ctrl
//   Sequencer for the conv-layer input row buffer and KxK kernel datapath.
//   Preloads KERNEL_SIZE image rows, walks the kernel rows across every output
//   column, inserts one bias cycle per output row, then loads one new image row
//   per following output row. Also gates the upstream pixel source (data_req).
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     ctrl_if  slave side of conv_layer_input_ctrl_if (start in, status out)
//   All outputs are registered except busy and data_req, which are decoded
//   directly from the state/column registers.
// ----------------------------------------------------------------------------
module conv_layer_input_ctrl #(
  parameter int unsigned IMAGE_SIZE       = 8,
  parameter int unsigned KERNEL_SIZE      = 3,
  parameter int unsigned BUFFER_COL_WIDTH = 4,
  parameter int unsigned BUFFER_ROW_WIDTH = 2,
  parameter int unsigned OUT_ROW_WIDTH    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_input_ctrl_if.slave ctrl_if
);

  localparam int unsigned OUT = IMAGE_SIZE - KERNEL_SIZE + 1;

  // Terminal counts
  localparam logic [BUFFER_COL_WIDTH-1:0] COL_SHIFT    = BUFFER_COL_WIDTH'(IMAGE_SIZE);
  localparam logic [BUFFER_COL_WIDTH-1:0] COL_PIX_LAST = BUFFER_COL_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [BUFFER_COL_WIDTH-1:0] COL_OUT_LAST = BUFFER_COL_WIDTH'(OUT - 1);
  localparam logic [BUFFER_ROW_WIDTH-1:0] ROW_LAST     = BUFFER_ROW_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [OUT_ROW_WIDTH-1:0]    OROW_LAST    = OUT_ROW_WIDTH'(OUT - 1);

  localparam logic [BUFFER_COL_WIDTH-1:0] COL_ONE  = BUFFER_COL_WIDTH'(1);
  localparam logic [BUFFER_ROW_WIDTH-1:0] ROW_ONE  = BUFFER_ROW_WIDTH'(1);
  localparam logic [OUT_ROW_WIDTH-1:0]    OROW_ONE = OUT_ROW_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_BIAS    = 3'd3,
    ST_LOAD    = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [BUFFER_COL_WIDTH-1:0] col_q,   col_d;
  logic [BUFFER_ROW_WIDTH-1:0] row_q,   row_d;
  logic [BUFFER_ROW_WIDTH-1:0] pre_q,   pre_d;
  logic [OUT_ROW_WIDTH-1:0]    orow_q,  orow_d;
  logic                        done_q,  done_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      pre_q   <= '0;
      orow_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pre_q   <= pre_d;
      orow_q  <= orow_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pre_d   = pre_q;
    orow_d  = orow_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        col_d  = '0;
        row_d  = '0;
        pre_d  = '0;
        orow_d = '0;
        if (ctrl_if.start) begin
          state_d = ST_PRELOAD;
        end
      end

      ST_PRELOAD: begin
        if (pre_q != ROW_LAST) begin
          // Non-final rows end with an extra count used as the buffer row shift
          if (col_q == COL_SHIFT) begin
            col_d = '0;
            pre_d = pre_q + ROW_ONE;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          // Final preload row goes straight into the kernel walk, no shift cycle
          if (col_q == COL_PIX_LAST) begin
            state_d = ST_SHIFT;
            col_d   = '0;
            row_d   = '0;
            pre_d   = '0;
            orow_d  = '0;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end

      ST_SHIFT: begin
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (col_q == COL_OUT_LAST) begin
            state_d = ST_BIAS;
            col_d   = '0;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end

      ST_BIAS: begin
        col_d = '0;
        row_d = '0;
        if (orow_q != OROW_LAST) begin
          state_d = ST_LOAD;
        end else begin
          // Frame complete: done coincides with the first IDLE cycle
          state_d = ST_IDLE;
          orow_d  = '0;
          done_d  = 1'b1;
        end
      end

      ST_LOAD: begin
        if (col_q == COL_PIX_LAST) begin
          state_d = ST_SHIFT;
          col_d   = '0;
          row_d   = '0;
          orow_d  = orow_q + OROW_ONE;
        end else begin
          col_d = col_q + COL_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
        pre_d   = '0;
        orow_d  = '0;
      end
    endcase
  end

  // Registered outputs
  assign ctrl_if.current_state = state_q;
  assign ctrl_if.col_index     = col_q;
  assign ctrl_if.row_index     = row_q;
  assign ctrl_if.preload_cycle = pre_q;
  assign ctrl_if.out_row       = orow_q;
  assign ctrl_if.done          = done_q;

  // Decoded outputs; the preload shift count is the only non-request column
  assign ctrl_if.busy     = (state_q != ST_IDLE);
  assign ctrl_if.data_req = ((state_q == ST_PRELOAD) && (col_q < COL_SHIFT)) ||
                            (state_q == ST_LOAD);

endmodule : conv_layer_input_ctrl

// File: tb/tb_conv_layer_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_conv_layer_input_ctrl
//   Scoreboard bench: on every start the full expected per-cycle output trace
//   is built from the frame structure and queued; each cycle the observed
//   outputs are popped against it. Frame-level counts are checked afterwards.
// ----------------------------------------------------------------------------
module tb_conv_layer_input_ctrl;

  localparam int IMG   = 8;
  localparam int K     = 3;
  localparam int OUTN  = IMG - K + 1;
  localparam int FRAME = 181;

  // {state, col, row, preload, data_req, out_row, busy, done}
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] col;
    logic [1:0] row;
    logic [1:0] pre;
    logic       dreq;
    logic [2:0] orow;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  obs_t exp_q[$];

  conv_layer_input_ctrl_if #(
    .BUFFER_COL_WIDTH(4),
    .BUFFER_ROW_WIDTH(2),
    .OUT_ROW_WIDTH   (3)
  ) bus ();

  conv_layer_input_ctrl #(
    .IMAGE_SIZE      (IMG),
    .KERNEL_SIZE     (K),
    .BUFFER_COL_WIDTH(4),
    .BUFFER_ROW_WIDTH(2),
    .OUT_ROW_WIDTH   (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_if(bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st   = bus.current_state;
    o.col  = bus.col_index;
    o.row  = bus.row_index;
    o.pre  = bus.preload_cycle;
    o.dreq = bus.data_req;
    o.orow = bus.out_row;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  function automatic obs_t mk(int st, int col, int row, int pre, int dreq, int orow,
                              int busy, int done);
    obs_t o;
    o.st   = 3'(st);
    o.col  = 4'(col);
    o.row  = 2'(row);
    o.pre  = 2'(pre);
    o.dreq = 1'(dreq);
    o.orow = 3'(orow);
    o.busy = 1'(busy);
    o.done = 1'(done);
    return o;
  endfunction

  // Expected outputs for each cycle after the start edge, ending with the done cycle
  task automatic push_frame();
    for (int p = 0; p < K; p++) begin
      int last_col;
      last_col = (p < K - 1) ? IMG : IMG - 1;
      for (int c = 0; c <= last_col; c++)
        exp_q.push_back(mk(1, c, 0, p, (c < IMG) ? 1 : 0, 0, 1, 0));
    end
    for (int r = 0; r < OUTN; r++) begin
      for (int c = 0; c < OUTN; c++)
        for (int k = 0; k < K; k++)
          exp_q.push_back(mk(2, c, k, 0, 0, r, 1, 0));
      exp_q.push_back(mk(3, 0, 0, 0, 0, r, 1, 0));
      if (r < OUTN - 1)
        for (int c = 0; c < IMG; c++)
          exp_q.push_back(mk(4, c, 0, 0, 1, r, 1, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic run_frame(input bit inject, input bit abort);
    int   n_dreq, n_bias, n_load, n_shift, done_cyc, cyc;
    bit   aborted;
    obs_t o, e;
    n_dreq = 0; n_bias = 0; n_load = 0; n_shift = 0; done_cyc = -1; aborted = 0;
    exp_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    push_frame();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
      o = sample();
      if (abort && o.st == 3'd4 && o.orow == 3'd3 && o.col == 4'd2) begin
        rst_n = 1'b0;
        #1;
        chk_eq("mid_frame_reset", 32'(sample()), 32'd0);
        aborted = 1'b1;
        break;
      end
      e = exp_q.pop_front();
      chk_eq($sformatf("trace_c%0d", cyc), 32'(o), 32'(e));
      if (o.dreq)       n_dreq++;
      if (o.st == 3'd3) n_bias++;
      if (o.st == 3'd4) n_load++;
      if (o.st == 3'd2) n_shift++;
      if (o.done && done_cyc < 0) done_cyc = cyc;
      // Extra start pulses mid-frame must have no effect
      if (inject && ((o.st == 3'd2 && o.col == 4'd1 && o.row == 2'd0) ||
                     (o.st == 3'd4 && o.col == 4'd3)))
        bus.start = 1'b1;
    end
    bus.start = 1'b0;
    if (abort) begin
      chk_eq("abort_reached", 32'(aborted), 32'd1);
      exp_q.delete();
    end else begin
      chk_eq("frame_timeout_left", 32'(exp_q.size()), 32'd0);
      chk_eq("frame_len",  32'(done_cyc), 32'(FRAME));
      chk_eq("data_req_n", 32'(n_dreq),   32'd64);
      chk_eq("bias_n",     32'(n_bias),   32'd6);
      chk_eq("load_n",     32'(n_load),   32'd40);
      chk_eq("shift_n",    32'(n_shift),  32'd108);
      @(posedge clk);
      #1;
      chk_eq("post_idle", 32'(sample()), 32'd0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;

    // Reset values and idle hold
    #12;
    chk_eq("reset_outputs", 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk_eq("idle_hold", 32'(bus.current_state), 32'd0);
    end

    // Clean frame, then frame with ignored start pulses
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // Reset in LOAD with out_row=3, then a clean frame
    run_frame(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_held", 32'(sample()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_conv_layer_input_ctrl
